// File: rtl/network_result_capture_pkg.sv
// Shared constants and the occupancy state type for the network result capture slice.
package network_result_capture_pkg;

  localparam int unsigned RESULT_READY_BIT = 0;
  localparam int unsigned TAG_W            = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/network_result_capture_result_fifo.sv
// Result storage: circular buffer with natural-wrap pointers and an occupancy count.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Head reads as zero while empty so stale words never appear after a reset.
  assign rdata = (cnt != '0) ? mem[rptr] : '0;
  assign count = cnt;

endmodule

// File: rtl/network_result_capture.sv
// Captures one network result per rising edge of result_ready into a tagged FIFO for the host.
module network_result_capture
  import network_result_capture_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             control_out,
  input  logic [DATA_W-1:0]      data_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic [$clog2(DEPTH):0] res_count,
  output logic                   ovf,
  input  logic                   clr_ovf
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic                    ready_q;
  logic [TAG_W-1:0]        tag_cnt;
  occ_state_t              state;
  occ_state_t              state_nx;
  logic                    ovf_q;
  logic                    capture;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    overflow;
  logic [CW-1:0]           count;
  logic [TAG_W+DATA_W-1:0] head;
  logic                    ctrl_unused;

  assign ctrl_unused = ^control_out[7:1];

  assign capture  = control_out[RESULT_READY_BIT] && !ready_q;
  assign full     = (state == OCC_FULL);
  assign res_valid = (state != OCC_EMPTY);
  assign pop      = res_valid && res_ready;
  // A capture while full is still accepted when the head leaves in the same cycle.
  assign push     = capture && (!full || pop);
  assign overflow = capture && full && !pop;

  always_comb begin
    state_nx = state;
    case (state)
      OCC_EMPTY:   if (push) state_nx = OCC_PARTIAL;
      OCC_PARTIAL: begin
        if (push && !pop && count == LAST_CNT)     state_nx = OCC_FULL;
        else if (pop && !push && count == ONE_CNT) state_nx = OCC_EMPTY;
      end
      OCC_FULL:    if (pop && !push) state_nx = OCC_PARTIAL;
      default:     state_nx = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      tag_cnt <= '0;
      state   <= OCC_EMPTY;
      ovf_q   <= 1'b0;
    end else begin
      ready_q <= control_out[RESULT_READY_BIT];
      if (capture) tag_cnt <= tag_cnt + 1'b1;
      state <= state_nx;
      if (overflow)     ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TAG_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({tag_cnt, data_out}),
    .rdata (head),
    .count (count)
  );

  assign res_data  = head[DATA_W-1:0];
  assign res_tag   = head[DATA_W +: TAG_W];
  assign res_count = count;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_network_result_capture.sv
// Bench for network_result_capture: queue-based model checked every cycle plus directed literal checks.
module tb_network_result_capture;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    control_out = 8'h00;
  logic [DW-1:0] data_out = '0;
  logic          res_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [7:0]    res_tag;
  logic [2:0]    res_count;
  logic          ovf;

  int checks = 0;
  int failures = 0;

  network_result_capture #(
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .control_out (control_out),
    .data_out    (data_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_count   (res_count),
    .ovf         (ovf),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of {tag,data} entries, a tag counter and a sticky flag.
  typedef struct {
    logic [7:0]    tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t       mq[$];
  logic       m_prev = 1'b0;
  logic [7:0] m_tag = 8'd0;
  logic       m_ovf = 1'b0;
  bit         m_cap;
  bit         m_pop;
  bit         m_drop;
  ent_t       m_ent;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_prev = 1'b0;
      m_tag  = 8'd0;
      m_ovf  = 1'b0;
    end else begin
      m_cap  = control_out[0] && !m_prev;
      m_prev = control_out[0];
      m_pop  = (mq.size() > 0) && res_ready;
      m_drop = m_cap && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_cap) begin
        if (!m_drop) begin
          m_ent.tag  = m_tag;
          m_ent.data = data_out;
          mq.push_back(m_ent);
        end
        m_tag = m_tag + 8'd1;
      end
      if (m_drop)       m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmp_valid", res_valid, mq.size() != 0);
    chk("cmp_count", res_count, mq.size());
    chk("cmp_ovf", ovf, m_ovf);
    if (mq.size() != 0) begin
      chk("cmp_data", res_data, mq[0].data);
      chk("cmp_tag", res_tag, mq[0].tag);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    control_out = 8'h00;
    res_ready = 1'b0;
    clr_ovf = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Upper control bits toggle while low to show they never trigger a capture.
  task automatic pulse(input logic [DW-1:0] d);
    control_out = 8'h01;
    data_out = d;
    tick();
    control_out = 8'hFE;
    tick();
  endtask

  initial begin
    logic [DW-1:0] exp_d [4];
    logic [7:0]    exp_t [4];

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", res_count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", res_data, 0);
    chk("rst_tag", res_tag, 0);

    // single result, level held three cycles
    tick();
    control_out = 8'h01;
    data_out = 232;
    @(negedge clk);
    chk("t1_valid_before", res_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_valid", res_valid, 1);
    chk("t1_data", res_data, 232);
    chk("t1_tag", res_tag, 0);
    tick();
    tick();
    control_out = 8'h00;
    tick();
    chk("t1_count", res_count, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t1_empty", res_valid, 0);

    // fill and drain
    do_reset();
    for (int i = 0; i < 4; i++) pulse(DW'(i + 1));
    chk("t2_count", res_count, 4);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_data", res_data, i + 1);
      chk("t2_tag", res_tag, i);
      tick();
    end
    @(negedge clk);
    chk("t2_empty", res_valid, 0);
    res_ready = 1'b0;

    // overflow
    do_reset();
    for (int i = 0; i < 5; i++) pulse(DW'(10 + i));
    chk("t3_count", res_count, 4);
    chk("t3_ovf", ovf, 1);
    chk("t3_head", res_data, 10);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    pulse(20);
    chk("t3_count2", res_count, 4);
    exp_d = '{11, 12, 13, 20};
    exp_t = '{1, 2, 3, 5};
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_data", res_data, exp_d[i]);
      chk("t3_tag", res_tag, exp_t[i]);
      tick();
    end
    res_ready = 1'b0;
    chk("t3_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", ovf, 0);
    for (int i = 0; i < 4; i++) pulse(DW'(30 + i));
    control_out = 8'h01;
    data_out = 34;
    clr_ovf = 1'b1;
    tick();
    control_out = 8'hFE;
    clr_ovf = 1'b0;
    chk("t3_ovf_keep", ovf, 1);
    tick();

    // full push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) pulse(DW'(i + 1));
    control_out = 8'h01;
    data_out = 99;
    res_ready = 1'b1;
    tick();
    control_out = 8'hFE;
    res_ready = 1'b0;
    chk("t4_count", res_count, 4);
    chk("t4_ovf", ovf, 0);
    exp_d = '{2, 3, 4, 99};
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_data", res_data, exp_d[i]);
      tick();
    end
    res_ready = 1'b0;
    chk("t4_empty", res_valid, 0);

    // asynchronous reset mid-operation, level high at release
    do_reset();
    pulse(5);
    pulse(6);
    chk("t5_count_pre", res_count, 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_valid", res_valid, 0);
    chk("t5_count", res_count, 0);
    control_out = 8'h01;
    data_out = 77;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid_rel", res_valid, 0);
    tick();
    chk("t5_valid_cap", res_valid, 1);
    chk("t5_data", res_data, 77);
    chk("t5_tag", res_tag, 0);
    control_out = 8'hFE;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // tag wrap with continuous draining
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      control_out = 8'h01;
      data_out = DW'(i);
      tick();
      if (i == 0 || i == 255 || i == 256) chk("t6_tag", res_tag, i & 255);
      control_out = 8'hFE;
      tick();
    end
    @(negedge clk);
    chk("t6_empty", res_valid, 0);
    res_ready = 1'b0;

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/network_result_capture.md
NETWORK_RESULT_CAPTURE -- requirements
Module: network_result_capture

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 Parameter DATA_W, default 32, result word width, matching the network int output.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 control_out  input  8  network status; bit0 = result_ready level; bits 7:1 ignored.
REQ-006 data_out  input  DATA_W  network result word (signed), stable while control_out[0] high.
REQ-007 res_valid  output  1  head entry available to host.
REQ-008 res_ready  input  1  host accepts head entry.
REQ-009 res_data  output  DATA_W  head entry result word.
REQ-010 res_tag  output  8  head entry sequence tag.
REQ-011 res_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 ovf  output  1  sticky overflow flag.
REQ-013 clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-014 Capture event SHALL be rising edge of control_out[0]: current high, previous-cycle registered value low.
REQ-015 On a capture event, data_out SHALL be sampled in that same cycle; the entry SHALL be written at that clock edge.
REQ-016 Each capture event SHALL increment an 8-bit tag counter, wrapping 255->0, regardless of whether the entry is stored.
REQ-017 The stored entry tag SHALL be the tag counter value before increment; the first capture after reset is tag 0.
REQ-018 res_valid SHALL be high whenever count>0; res_data/res_tag SHALL show the head entry with no combinational path from inputs.
REQ-019 Latency: entry visible on res_valid one cycle after the capture cycle.
REQ-020 Pop SHALL occur when res_valid && res_ready at a clock edge; with res_valid low, res_ready SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; this SHALL hold when full, so a push while full with a pop is accepted.
REQ-022 Push while full without pop SHALL drop the sample, set ovf, keep the FIFO contents, and still advance the tag.
REQ-023 ovf SHALL remain set until clr_ovf; when clr_ovf and a new overflow occur in the same cycle, ovf SHALL stay set.
REQ-024 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap naturally.
REQ-025 A single state machine SHALL track occupancy: EMPTY, PARTIAL, FULL.
REQ-026 State transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on push reaching DEPTH; PARTIAL->EMPTY on pop reaching 0; FULL->PARTIAL on pop without push.
REQ-027 res_count SHALL equal the number of stored entries, 0..DEPTH.

Reset
REQ-028 rst SHALL clear pointers, count, tag counter, ovf, and the control_out[0] history register to 0, and set state to EMPTY.
REQ-029 After reset: res_valid=0, res_count=0, ovf=0; res_data/res_tag SHALL be 0.
REQ-030 rst mid-operation SHALL discard all stored entries; if control_out[0] is high at reset release, one capture SHALL occur on the first cycle.

Structure
REQ-031 A shared package SHALL hold the control_out bit index constant (RESULT_READY_BIT=0), the tag width (8), and the occupancy-state enum.
REQ-032 One sub-module, result_fifo (storage array, pointers, count), is natural; edge detection, tag counter, state machine and ovf logic SHALL live in the top module.

Verification
REQ-033 Single result: pulse control_out[0] high 3 cycles with data_out=232 -> one entry {232, tag 0}; res_valid high one cycle after the edge; level-high cycles after the edge add no entries.
REQ-034 Fill and drain: 4 edges with data 1,2,3,4 and res_ready=0 -> count=4, state FULL; then res_ready=1 -> data 1,2,3,4 with tags 0..3 in order, then res_valid=0.
REQ-035 Overflow: 5 edges with data 10..14 and no pops -> FIFO holds 10..13, ovf=1; the next stored entry carries tag 5; clr_ovf -> ovf=0.
REQ-036 Full push and pop: FULL, edge with data 99 and res_ready=1 in the same cycle -> count stays 4, ovf stays 0, 99 is last out.
REQ-037 Reset mid-op: 2 entries stored, rst asserted asynchronously between clock edges -> res_valid drops immediately, count=0; next capture has tag 0.
REQ-038 Tag wrap: 257 edges with continuous draining -> tags run 0..255 then 0.
